// File: rtl/pmod_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pmod_pattern_sequencer
//
// Timed LED pattern generator for the iCESugar-nano PMOD header. A prescaler
// produces one step tick every TICK_DIV clocks. Each tick advances the pattern
// of the current mode and toggles a heartbeat. A debounced push-button steps
// the mode COUNT -> SCAN -> FILL -> BLINK -> COUNT.
//
// Parameters
//   TICK_DIV   : clock cycles per pattern step (2 .. 2^24)
//   DEB_CYCLES : cycles the synchronized button must be stable (1 .. 2^20)
//
// Ports
//   i_clk   : board clock, all flops on the rising edge
//   i_rst_n : synchronous active-low reset
//   i_btn   : raw push-button, active-high, asynchronous to i_clk
//   o_pmod  : active-low LED drive (inverted pattern register)
//   o_led   : active-low heartbeat (inverted heartbeat register)
//   o_mode  : current mode (0 COUNT, 1 SCAN, 2 FILL, 3 BLINK)
// -----------------------------------------------------------------------------
module pmod_pattern_sequencer #(
  parameter int unsigned TICK_DIV   = 1_500_000,
  parameter int unsigned DEB_CYCLES = 120_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  output logic [7:0] o_pmod,
  output logic       o_led,
  output logic [1:0] o_mode
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  // A one-cycle debounce would give a zero-width counter; keep at least 1 bit.
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DC_LAST = DW'(DEB_CYCLES - 1);

  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_SCAN  = 2'd1;
  localparam logic [1:0] MODE_FILL  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Pattern loaded when a mode is entered; only SCAN starts with a lit LED.
  function automatic logic [7:0] start_pat(input logic [1:0] mode);
    logic [7:0] pat;
    case (mode)
      MODE_SCAN: pat = 8'h01;
      default:   pat = 8'h00;
    endcase
    return pat;
  endfunction

  logic [PW-1:0] r_p;
  logic [1:0]    r_mode;
  logic [7:0]    r_pat;
  logic          r_dir;
  logic          r_hb;
  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic [DW-1:0] r_dc;

  logic          w_tick;
  logic          w_deb_rise;
  logic [1:0]    w_mode_next;
  logic [7:0]    w_pat_step;
  logic          w_dir_step;

  assign w_tick      = (r_p == P_LAST);
  // deb rises on this edge when the synchronized level (1) differs from deb
  // (0) and the stability counter has run out.
  assign w_deb_rise  = (r_s2 == 1'b1) && (r_deb == 1'b0) && (r_dc == DC_LAST);
  assign w_mode_next = r_mode + 2'd1;

  // Next pattern and scan direction for one step of the current mode.
  always_comb begin
    w_pat_step = r_pat;
    w_dir_step = r_dir;
    case (r_mode)
      MODE_COUNT: begin
        w_pat_step = r_pat + 8'd1;
      end
      MODE_SCAN: begin
        // The end LED is shown for one step before the bounce back.
        if (r_dir == DIR_UP) begin
          if (r_pat == 8'h80) begin
            w_pat_step = 8'h40;
            w_dir_step = DIR_DOWN;
          end else begin
            w_pat_step = {r_pat[6:0], 1'b0};
          end
        end else begin
          if (r_pat == 8'h01) begin
            w_pat_step = 8'h02;
            w_dir_step = DIR_UP;
          end else begin
            w_pat_step = {1'b0, r_pat[7:1]};
          end
        end
      end
      MODE_FILL: begin
        if (r_pat == 8'hFF) begin
          w_pat_step = 8'h00;
        end else begin
          w_pat_step = {r_pat[6:0], 1'b1};
        end
      end
      MODE_BLINK: begin
        w_pat_step = ~r_pat;
      end
      default: begin
        w_pat_step = 8'h00;
        w_dir_step = DIR_UP;
      end
    endcase
  end

  // Button synchronizer and debounce counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_dc  <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_dc <= '0;
      end else if (r_dc == DC_LAST) begin
        r_deb <= r_s2;
        r_dc  <= '0;
      end else begin
        r_dc <= r_dc + DW'(1);
      end
    end
  end

  // Heartbeat toggles on every tick, whether or not the mode changes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hb <= 1'b0;
    end else if (w_tick) begin
      r_hb <= ~r_hb;
    end else begin
      r_hb <= r_hb;
    end
  end

  // Mode, prescaler and pattern. A mode advance takes priority over a
  // coincident tick: the new start value is loaded and no step is taken,
  // and the prescaler restarts so the next step is a full period later.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_p    <= '0;
      r_mode <= MODE_COUNT;
      r_pat  <= 8'h00;
      r_dir  <= DIR_UP;
    end else if (w_deb_rise) begin
      r_p    <= '0;
      r_mode <= w_mode_next;
      r_pat  <= start_pat(w_mode_next);
      r_dir  <= DIR_UP;
    end else if (w_tick) begin
      r_p    <= '0;
      r_mode <= r_mode;
      r_pat  <= w_pat_step;
      r_dir  <= w_dir_step;
    end else begin
      r_p    <= r_p + PW'(1);
      r_mode <= r_mode;
      r_pat  <= r_pat;
      r_dir  <= r_dir;
    end
  end

  // Outputs are straight from registers through an inverter (active-low LEDs).
  assign o_pmod = ~r_pat;
  assign o_led  = ~r_hb;
  assign o_mode = r_mode;

endmodule

// File: tb/tb_pmod_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for pmod_pattern_sequencer with TICK_DIV=4, DEB_CYCLES=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_pmod_pattern_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic [7:0] pmod;
  logic       led;
  logic [1:0] mode;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] scan_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] fill_seq [9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                8'hFF, 8'h00};

  always #5 clk = ~clk;

  pmod_pattern_sequencer #(
    .TICK_DIV   (4),
    .DEB_CYCLES (3)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (btn),
    .o_pmod  (pmod),
    .o_led   (led),
    .o_mode  (mode)
  );

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_pat(input string tag, input logic [7:0] exp_pat);
    chk(tag, pmod, ~exp_pat);
  endtask

  task automatic chk_mode(input string tag, input logic [1:0] exp_mode);
    chk(tag, {6'd0, mode}, {6'd0, exp_mode});
  endtask

  task automatic chk_led(input string tag, input logic exp_led);
    chk(tag, {7'd0, led}, {7'd0, exp_led});
  endtask

  // Press from a step boundary (prescaler at 0); advance lands 5 edges later.
  task automatic press(input string tag, input logic [1:0] exp_mode, input logic [7:0] exp_start);
    btn = 1'b1;
    edges(5);
    chk_mode({tag, "_mode"}, exp_mode);
    chk_pat({tag, "_start"}, exp_start);
    btn = 1'b0;
  endtask

  initial begin
    // Reset held for three edges.
    edges(3);
    chk_pat("rst_pmod", 8'h00);
    chk_led("rst_led", 1'b1);
    chk_mode("rst_mode", 2'd0);
    rst_n = 1'b1;

    // First step exactly at the 4th edge after release, second at the 8th.
    edges(3);
    chk_pat("pre_tick1", 8'h00);
    edges(1);
    chk_pat("tick1_pat", 8'h01);
    chk_led("tick1_led", 1'b0);
    edges(4);
    chk_pat("tick2_pat", 8'h02);
    chk_led("tick2_led", 1'b1);

    // COUNT through FF and wrap to 00.
    for (int i = 3; i <= 255; i++) begin
      edges(4);
      chk_pat("count", 8'(i));
    end
    edges(4);
    chk_pat("count_wrap", 8'h00);
    chk_led("count_wrap_led", 1'b1);

    // Bounce: 2 high / 1 low, ten times; debounce never completes.
    for (int k = 0; k < 10; k++) begin
      btn = 1'b1;
      edges(2);
      btn = 1'b0;
      edges(1);
    end
    edges(2);
    chk_mode("bounce_mode", 2'd0);
    chk_pat("bounce_pat", 8'h08);

    // Clean press held ~21 cycles: COUNT ticks at edge 4, SCAN at edge 5.
    btn = 1'b1;
    edges(4);
    chk_mode("press_e4_mode", 2'd0);
    chk_pat("press_e4_pat", 8'h09);
    edges(1);
    chk_mode("press_e5_mode", 2'd1);
    chk_pat("press_e5_pat", 8'h01);
    chk_led("press_e5_led", 1'b0);
    edges(3);
    chk_pat("scan_hold", 8'h01);
    edges(1);
    chk_pat("scan0", scan_seq[0]);
    for (int k = 1; k < 15; k++) begin
      edges(4);
      chk_pat("scan", scan_seq[k]);
      if (k == 3) btn = 1'b0;
    end
    chk_mode("release_mode", 2'd1);

    // FILL, BLINK, back to COUNT.
    press("to_fill", 2'd2, 8'h00);
    for (int k = 0; k < 9; k++) begin
      edges(4);
      chk_pat("fill", fill_seq[k]);
    end
    press("to_blink", 2'd3, 8'h00);
    edges(4);
    chk_pat("blink1", 8'hFF);
    edges(4);
    chk_pat("blink2", 8'h00);
    press("to_count", 2'd0, 8'h00);
    edges(4);
    chk_pat("count_re1", 8'h01);
    edges(4);
    chk_pat("count_re2", 8'h02);

    // Collision: debounce completes on the same edge as a tick.
    edges(3);
    btn = 1'b1;
    edges(4);
    chk_mode("coll_pre_mode", 2'd0);
    chk_pat("coll_pre_pat", 8'h03);
    chk_led("coll_pre_led", 1'b0);
    edges(1);
    chk_mode("coll_mode", 2'd1);
    chk_pat("coll_pat", 8'h01);
    chk_led("coll_led", 1'b1);
    edges(3);
    chk_pat("coll_hold", 8'h01);
    edges(1);
    chk_pat("coll_next", 8'h02);
    chk_led("coll_next_led", 1'b0);
    btn = 1'b0;
    edges(6);

    // Reset in the middle of a debounce, button still held afterwards.
    btn = 1'b1;
    edges(3);
    rst_n = 1'b0;
    edges(1);
    chk_mode("mid_rst_mode", 2'd0);
    chk_pat("mid_rst_pat", 8'h00);
    chk_led("mid_rst_led", 1'b1);
    rst_n = 1'b1;
    edges(4);
    chk_mode("post_rst_e4_mode", 2'd0);
    chk_pat("post_rst_e4_pat", 8'h01);
    edges(1);
    chk_mode("post_rst_e5_mode", 2'd1);
    chk_pat("post_rst_e5_pat", 8'h01);
    btn = 1'b0;
    edges(5);
    chk_mode("final_mode", 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
